// File: rtl/mdu_pkg.sv
// mdu_pkg: shared state encoding, opcode values and default width for the multiply/divide unit.
package mdu_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: execute-stage request/response bundle between the pipeline and the multiply/divide unit.
interface mdu_ctrl_if #(parameter int WIDTH = 32);
  logic startE;
  logic opE;
  logic hassignE;
  logic flushE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic [1:0] hilo_enE;
  logic [WIDTH-1:0] hilo_wdataE;
  logic stallE;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic busy_o;
  modport master (
    output startE, opE, hassignE, flushE, srcaE, srcbE, hilo_enE, hilo_wdataE,
    input stallE, hi_o, lo_o, busy_o
  );
  modport slave (
    input startE, opE, hassignE, flushE, srcaE, srcbE, hilo_enE, hilo_wdataE,
    output stallE, hi_o, lo_o, busy_o
  );
endinterface

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: unsigned shift-add multiply / restoring divide datapath, one bit per step.
module mdu_iter_core import mdu_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             op,
  input  logic [WIDTH-1:0] loInit,
  input  logic [WIDTH-1:0] opnd,
  output logic             last,
  output logic [WIDTH-1:0] hiNext,
  output logic [WIDTH-1:0] loNext
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] acc, accNext, mulNext, divNext;
  logic [WIDTH-1:0] opReg;
  logic [WIDTH:0] sum, trial;
  logic [CW-1:0] cnt;
  logic opR;
  // Multiply keeps the adder carry as the new accumulator MSB; divide trial-subtracts one bit wider than rem.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opReg} : '0);
  assign mulNext = {sum, acc[WIDTH-1:1]};
  assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opReg};
  assign divNext = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign accNext = opR == OP_DIV ? divNext : mulNext;
  assign hiNext = accNext[2*WIDTH-1:WIDTH];
  assign loNext = accNext[WIDTH-1:0];
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      opReg <= '0;
      opR <= OP_MUL;
      cnt <= '0;
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, loInit};
      opReg <= opnd;
      opR <= op;
      cnt <= '0;
    end else if (step) begin
      acc <= accNext;
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer with HI/LO registers and pipeline stall for the execute stage.
module mdu_ctrl import mdu_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input logic      clk,
  input logic      rst,
  mdu_ctrl_if.slave bus
);
  state_t state;
  logic resNeg, remNeg, opR, aNeg, bNeg, divZero, start, last;
  logic [WIDTH-1:0] magA, magB, hiRaw, loRaw, quo, rem, hiReg, loReg;
  logic [2*WIDTH-1:0] prod;
  assign aNeg = bus.hassignE & bus.srcaE[WIDTH-1];
  assign bNeg = bus.hassignE & bus.srcbE[WIDTH-1];
  assign magA = aNeg ? -bus.srcaE : bus.srcaE;
  assign magB = bNeg ? -bus.srcbE : bus.srcbE;
  assign divZero = bus.opE == OP_DIV && bus.srcbE == '0;
  assign start = state == IDLE && bus.startE && !bus.flushE;
  mdu_iter_core #(.WIDTH(WIDTH)) core (
    .clk(clk),
    .rst(rst),
    .load(start),
    .step(state == BUSY),
    .op(bus.opE),
    .loInit(bus.opE == OP_DIV ? magA : magB),
    .opnd(bus.opE == OP_DIV ? magB : magA),
    .last(last),
    .hiNext(hiRaw),
    .loNext(loRaw)
  );
  // Remainder follows the dividend's sign; product and quotient follow the operand sign parity.
  assign prod = resNeg ? -{hiRaw, loRaw} : {hiRaw, loRaw};
  assign quo = resNeg ? -loRaw : loRaw;
  assign rem = remNeg ? -hiRaw : hiRaw;
  assign bus.stallE = !rst && (start || (state == BUSY && !bus.flushE));
  assign bus.busy_o = state != IDLE;
  assign bus.hi_o = hiReg;
  assign bus.lo_o = loReg;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hiReg <= '0;
      loReg <= '0;
      resNeg <= 1'b0;
      remNeg <= 1'b0;
      opR <= OP_MUL;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= divZero ? DONE : BUSY;
            opR <= bus.opE;
            resNeg <= aNeg ^ bNeg;
            remNeg <= aNeg;
          end else if (!bus.flushE) begin
            if (bus.hilo_enE[1]) hiReg <= bus.hilo_wdataE;
            if (bus.hilo_enE[0]) loReg <= bus.hilo_wdataE;
          end
        end
        BUSY: begin
          if (bus.flushE) state <= IDLE;
          else if (last) begin
            state <= DONE;
            hiReg <= opR == OP_DIV ? rem : prod[2*WIDTH-1:WIDTH];
            loReg <= opR == OP_DIV ? quo : prod[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench; issued mul/div ops push expected HI/LO and stall length, a monitor checks on completion.
module tb_mdu_ctrl;
  localparam int W = 32;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int stall;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mdu_ctrl_if #(.WIDTH(W)) bus();
  mdu_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t sb[$];
  exp_t monE;
  int monCnt = 0;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic and SV signed division (truncates toward zero).
  function automatic exp_t model(bit op, bit sgn, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint p;
    int q, r;
    e.stall = 33;
    if (!op) begin
      p = sgn ? longint'($signed(a)) * longint'($signed(b)) : longint'({32'b0, a}) * longint'({32'b0, b});
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.hi = mHi;
      e.lo = mLo;
      e.stall = 1;
    end else if (sgn && a == 32'h80000000 && b == 32'hffffffff) begin
      e.hi = 32'h0;
      e.lo = 32'h80000000;
    end else if (sgn) begin
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
      e.lo = q;
      e.hi = r;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (bus.stallE) monCnt++;
      else begin
        if (bus.busy_o && !bus.flushE && !rst) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL completion: got unexpected completion expected none");
          end else begin
            monE = sb.pop_front();
            check("hi", bus.hi_o, monE.hi);
            check("lo", bus.lo_o, monE.lo);
            check("stall_len", monCnt, monE.stall);
          end
        end
        monCnt = 0;
      end
    end
  end

  task automatic issue(bit op, bit sgn, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int n;
    e = model(op, sgn, a, b);
    sb.push_back(e);
    mHi = e.hi;
    mLo = e.lo;
    bus.startE = 1'b1;
    bus.opE = op;
    bus.hassignE = sgn;
    bus.srcaE = a;
    bus.srcbE = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.stallE && n < 100);
    if (n >= 100) begin
      compared++;
      mismatched++;
      $display("FAIL stall_timeout: got stall after %0d cycles expected release", n);
    end
    @(posedge clk);
    #1 bus.startE = 1'b0;
  endtask

  task automatic mt(logic [1:0] en, logic [31:0] d);
    bus.hilo_enE = en;
    bus.hilo_wdataE = d;
    @(posedge clk);
    #1 bus.hilo_enE = 2'b00;
    if (en[1]) mHi = d;
    if (en[0]) mLo = d;
    check("mt_hi", bus.hi_o, mHi);
    check("mt_lo", bus.lo_o, mLo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.startE = 0; bus.opE = 0; bus.hassignE = 0; bus.flushE = 0;
    bus.srcaE = 0; bus.srcbE = 0; bus.hilo_enE = 0; bus.hilo_wdataE = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_hi", bus.hi_o, 0);
    check("rst_lo", bus.lo_o, 0);
    check("rst_stall", bus.stallE, 0);
    check("rst_busy", bus.busy_o, 0);
    issue(0, 0, 32'hffffffff, 32'hffffffff);
    issue(0, 1, -32'sd3, 32'd5);
    issue(1, 1, -32'sd7, 32'd2);
    issue(1, 0, 32'd7, 32'd2);
    mt(2'b10, 32'hAA);
    mt(2'b01, 32'hBB);
    issue(1, 0, 32'd100, 32'd0);
    check("dz_hi", bus.hi_o, 32'hAA);
    check("dz_lo", bus.lo_o, 32'hBB);
    issue(1, 1, 32'h80000000, 32'hffffffff);
    bus.startE = 1'b1; bus.opE = 0; bus.hassignE = 1; bus.srcaE = 32'd123; bus.srcbE = -32'sd45;
    repeat (9) @(posedge clk);
    #1 bus.flushE = 1'b1;
    bus.startE = 1'b0;
    #1 check("flush_stall", bus.stallE, 0);
    @(posedge clk);
    #1 bus.flushE = 1'b0;
    check("flush_busy", bus.busy_o, 0);
    check("flush_hi", bus.hi_o, mHi);
    check("flush_lo", bus.lo_o, mLo);
    issue(1, 0, 32'd9, 32'd3);
    mt(2'b10, 32'h12345678);
    bus.startE = 1'b1; bus.opE = 0; bus.hassignE = 0; bus.srcaE = 32'd77; bus.srcbE = 32'd88;
    repeat (5) @(posedge clk);
    #1 bus.startE = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mHi = '0;
    mLo = '0;
    check("rstb_hi", bus.hi_o, 0);
    check("rstb_lo", bus.lo_o, 0);
    check("rstb_busy", bus.busy_o, 0);
    check("rstb_stall", bus.stallE, 0);
    repeat (30) begin
      if ($urandom_range(0, 9) < 2) mt(2'($urandom_range(1, 3)), $urandom);
      else issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick());
    end
    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
